// File: rtl/cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss handler that sits directly behind a cache. On a miss it captures the
// block base of the missing address, then issues one read per cycle for the
// eight 16-bit words of the block. Returned words arrive in request order with
// arbitrary latency and gaps. Each one is written into the cache data array,
// and the tag array is written together with the last word. fsm_busy stays
// high for the whole fill so the pipeline and the memory arbiter can stall.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous, active-high reset
//   miss_detected     cache miss flag (sampled only in IDLE)
//   miss_address      byte address that missed
//   memory_data_valid memory returns one word this cycle (in request order)
//   fsm_busy          fill in progress
//   mem_read_en       read request to memory this cycle
//   memory_address    byte address of the current memory request
//   write_data_array  write the returned word into the data array this cycle
//   cache_word_addr   byte address of the word being written into the cache
//   write_tag_array   one-cycle pulse that writes tag + valid for the block
// ----------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int OFFSET_BITS     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic [ADDR_WIDTH-1:0] cache_word_addr,
    output logic                  write_tag_array
);

    // One extra bit so the issue counter can reach WORDS_PER_BLOCK and park
    // there once every request has gone out.
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;

    localparam logic [CNT_W-1:0]      NUM_WORDS   = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]      LAST_WORD   = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]        recv_cnt_q, recv_cnt_d;
    logic [CNT_W-1:0]        issue_disp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        issue_disp       = issue_cnt_q;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        cache_word_addr  = '0;
        write_tag_array  = 1'b0;

        case (state_q)
            IDLE: begin
                // Returned data is meaningless here; only a miss matters.
                if (miss_detected) begin
                    base_d      = miss_address & ~OFFSET_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end
            end

            FILL: begin
                fsm_busy    = 1'b1;
                mem_read_en = (issue_cnt_q < NUM_WORDS);

                // After the last request the address bus keeps showing the
                // final word instead of running past the block.
                issue_disp     = mem_read_en ? issue_cnt_q : LAST_WORD;
                memory_address = base_q + ADDR_WIDTH'({issue_disp, 1'b0});

                write_data_array = memory_data_valid;
                cache_word_addr  = base_q + ADDR_WIDTH'({recv_cnt_q, 1'b0});
                write_tag_array  = memory_data_valid && (recv_cnt_q == LAST_WORD);

                if (mem_read_en) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end

                // The fill ends on the last returned word, regardless of how
                // long memory took; a miss seen here is simply not sampled.
                if (memory_data_valid) begin
                    if (recv_cnt_q == LAST_WORD) begin
                        state_d     = IDLE;
                        issue_cnt_d = '0;
                        recv_cnt_d  = '0;
                    end else begin
                        recv_cnt_d = recv_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
